// File: rtl/if_id_buffer.sv
// if_id_buffer: IF/ID pipeline register with a two-entry skid buffer, flush and bubble insertion.
module if_id_buffer #(
   parameter int INST_WIDTH = 32,
   parameter int PC_WIDTH = 32,
   parameter logic [INST_WIDTH-1:0] BUBBLE_INST = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INST_WIDTH-1:0] if_inst,
   input  logic [PC_WIDTH-1:0]   if_pc,
   input  logic                  if_valid,
   output logic                  if_ready,
   input  logic                  flush,
   output logic [INST_WIDTH-1:0] id_inst,
   output logic [PC_WIDTH-1:0]   id_pc,
   output logic                  id_valid,
   input  logic                  id_ready,
   output logic [1:0]            occupancy
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
   state_t state, state_n;
   logic [INST_WIDTH-1:0] skid_inst, main_inst_n, skid_inst_n;
   logic [PC_WIDTH-1:0] skid_pc, main_pc_n, skid_pc_n;
   logic in_fire, out_fire;
   assign in_fire = if_valid & if_ready;
   assign out_fire = id_valid & id_ready;
   assign occupancy = state;
   always_comb begin
      state_n = state;
      main_inst_n = id_inst;
      main_pc_n = id_pc;
      skid_inst_n = skid_inst;
      skid_pc_n = skid_pc;
      if (flush) state_n = EMPTY;
      else case (state)
         EMPTY: if (in_fire) begin
            state_n = ONE;
            main_inst_n = if_inst;
            main_pc_n = if_pc;
         end
         ONE: if (in_fire && out_fire) begin
            main_inst_n = if_inst;
            main_pc_n = if_pc;
         end else if (in_fire) begin
            state_n = TWO;
            skid_inst_n = if_inst;
            skid_pc_n = if_pc;
         end else if (out_fire) state_n = EMPTY;
         TWO: if (out_fire) begin
            state_n = ONE;
            main_inst_n = skid_inst;
            main_pc_n = skid_pc;
         end
         default: state_n = EMPTY;
      endcase
      // an empty stage always shows the bubble so decode never sees stale data
      main_inst_n = (state_n == EMPTY) ? BUBBLE_INST : main_inst_n;
      main_pc_n = (state_n == EMPTY) ? '0 : main_pc_n;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= EMPTY;
         id_valid <= 1'b0;
         if_ready <= 1'b1;
         id_inst <= BUBBLE_INST;
         id_pc <= '0;
         skid_inst <= '0;
         skid_pc <= '0;
      end else begin
         state <= state_n;
         id_valid <= state_n != EMPTY;
         if_ready <= state_n != TWO;
         id_inst <= main_inst_n;
         id_pc <= main_pc_n;
         skid_inst <= skid_inst_n;
         skid_pc <= skid_pc_n;
      end
   end
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: default and narrow-width instances checked against a queue model.
module tb_if_id_buffer;
   logic clk = 0;
   logic rst = 1;
   logic [31:0] if_inst = '0, if_pc = '0;
   logic if_valid = 0, flush = 0, id_ready = 0;
   logic if_ready0, id_valid0, if_ready1, id_valid1;
   logic [31:0] id_inst0, id_pc0;
   logic [15:0] id_inst1;
   logic [23:0] id_pc1;
   logic [1:0] occ0, occ1;
   int n_chk = 0, n_pass = 0;
   typedef struct {logic [31:0] inst; logic [31:0] pc;} ent_t;
   ent_t q[$];

   always #5 clk = ~clk;

   if_id_buffer d0 (
      .clk(clk), .rst(rst), .if_inst(if_inst), .if_pc(if_pc), .if_valid(if_valid),
      .if_ready(if_ready0), .flush(flush), .id_inst(id_inst0), .id_pc(id_pc0),
      .id_valid(id_valid0), .id_ready(id_ready), .occupancy(occ0));

   if_id_buffer #(.INST_WIDTH(16), .PC_WIDTH(24), .BUBBLE_INST(16'h0013)) d1 (
      .clk(clk), .rst(rst), .if_inst(if_inst[15:0]), .if_pc(if_pc[23:0]), .if_valid(if_valid),
      .if_ready(if_ready1), .flush(flush), .id_inst(id_inst1), .id_pc(id_pc1),
      .id_valid(id_valid1), .id_ready(id_ready), .occupancy(occ1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   task automatic check_all();
      int n = q.size();
      chk("d0_valid", 32'(id_valid0), 32'(n != 0));
      chk("d0_inst", id_inst0, n ? q[0].inst : 32'h0);
      chk("d0_pc", id_pc0, n ? q[0].pc : 32'h0);
      chk("d0_ready", 32'(if_ready0), 32'(n < 2));
      chk("d0_occ", 32'(occ0), 32'(n));
      chk("d1_valid", 32'(id_valid1), 32'(n != 0));
      chk("d1_inst", 32'(id_inst1), n ? 32'(q[0].inst[15:0]) : 32'h0013);
      chk("d1_pc", 32'(id_pc1), n ? 32'(q[0].pc[23:0]) : 32'h0);
      chk("d1_ready", 32'(if_ready1), 32'(n < 2));
      chk("d1_occ", 32'(occ1), 32'(n));
   endtask

   task automatic model_update();
      bit in_f, out_f;
      if (!rst) begin
         q.delete();
         return;
      end
      in_f = if_valid && q.size() < 2;
      out_f = id_ready && q.size() > 0;
      if (flush) q.delete();
      else begin
         if (out_f) void'(q.pop_front());
         if (in_f) q.push_back('{if_inst, if_pc});
      end
   endtask

   task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic rdy, input logic fl);
      @(negedge clk);
      check_all();
      if_valid = v; if_inst = ins; if_pc = p; id_ready = rdy; flush = fl;
      @(posedge clk);
      model_update();
   endtask

   initial begin
      #1 rst = 0;
      q.delete();
      for (int i = 0; i < 3; i++) cyc(1, 32'hDEAD_0000 + i, 32'h100 + i, 1, 0);
      #1 rst = 1;
      // streaming
      cyc(1, 32'hFFFF_A0A0, 32'hFF00_0000, 1, 0);
      cyc(1, 32'h1234_A0A1, 32'hFF00_0004, 1, 0);
      cyc(1, 32'h5678_A0A2, 32'hFF00_0008, 1, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      // skid fill then drain
      cyc(1, 32'hCAFE_0010, 32'h0000_0010, 0, 0);
      cyc(1, 32'hCAFE_0014, 32'h0000_0014, 0, 0);
      cyc(1, 32'hCAFE_0018, 32'h0000_0018, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      // flush from full with a valid input pending
      cyc(1, 32'hAAAA_0010, 32'h10, 0, 0);
      cyc(1, 32'hAAAA_0014, 32'h14, 0, 0);
      cyc(1, 32'hBBBB_0020, 32'h20, 0, 1);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      // async reset between edges while full
      cyc(1, 32'h7777_0030, 32'h30, 0, 0);
      cyc(1, 32'h7777_0034, 32'h34, 0, 0);
      @(negedge clk);
      check_all();
      #2 rst = 0;
      q.delete();
      #1 check_all();
      @(posedge clk);
      for (int i = 0; i < 2; i++) cyc(1, 32'h9999_0000, 32'h40, 1, 0);
      #1 rst = 1;
      cyc(1, 32'h4444_5555, 32'h00AB_CDEF, 0, 0);
      cyc(0, 0, 0, 1, 0);
      // random traffic
      for (int i = 0; i < 2000; i++)
         cyc(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
             1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
      @(negedge clk);
      check_all();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
